// File: rtl/fpga_comm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_comm_pkg
//  Description : Shared types and constants for the FPGA-to-FPGA serial link.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
package fpga_comm_pkg;

    // Transmitter control states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        BACKOFF = 3'd2,
        SHIFT   = 3'd3,
        FINISH  = 3'd4,
        DONE    = 3'd5
    } tx_state_t;

    // Quiet cycles on send_to_other between two request attempts
    localparam int BACKOFF_CYCLES = 2;

    // Depth of the acknowledge synchroniser
    localparam int SYNC_STAGES = 2;

    // Retry counter width, wide enough for MAX_RETRY up to 15
    localparam int RETRY_W = 4;

endpackage
`default_nettype wire

// File: rtl/fpga_shift_register_param.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_shift_register_param
//  Description : Parallel-load, serial-out shift register with selectable
//                bit order (LSB_FIRST=1 sends bit 0 first).
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module fpga_shift_register_param #(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  shift_i,
    output logic                  serial_o
);

    logic [DATA_WIDTH-1:0] sr_q;
    logic [DATA_WIDTH-1:0] sr_shifted;
    logic [DATA_WIDTH-1:0] sr_d;

    // The exposed bit always sits at the end that leaves first
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign sr_shifted = {1'b0, sr_q[DATA_WIDTH-1:1]};
            assign serial_o   = sr_q[0];
        end else begin : g_msb_first
            assign sr_shifted = {sr_q[DATA_WIDTH-2:0], 1'b0};
            assign serial_o   = sr_q[DATA_WIDTH-1];
        end
    endgenerate

    // Load has priority over shift so a new word is never corrupted
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = sr_shifted;
        end
    end

    // Shift register storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpga_transmitter_param.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_transmitter_param
//  Description : FPGA-to-FPGA serial transmitter. Requests the link, waits for
//                a synchronised acknowledge (with timeout and bounded retry),
//                shifts the word out one bit per clock and runs the finish
//                handshake.
//                Optional macro FPGA_TX_PARITY_EN appends an even-parity bit.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module fpga_transmitter_param
    import fpga_comm_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 255,
    parameter int MAX_RETRY   = 3,
    parameter int LSB_FIRST   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    input  logic                  acknowledge,
    output logic                  send_to_other,
    output logic                  data_out,
    output logic                  data_valid,
    output logic                  finish,
    output logic                  finish_sent,
    output logic                  timeout_err
);

    localparam int TIMER_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int BITCNT_W = $clog2(DATA_WIDTH + 1);
`ifdef FPGA_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
    localparam int FRAME_BITS = DATA_WIDTH;
`endif

    // The timer counts 0..ACK_TIMEOUT-1 so a window is exactly ACK_TIMEOUT cycles
    localparam logic [TIMER_W-1:0]  TIMER_LAST   = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0]  TIMER_MAX    = TIMER_W'(ACK_TIMEOUT);
    localparam logic [TIMER_W-1:0]  BACKOFF_LAST = TIMER_W'(BACKOFF_CYCLES - 1);
    localparam logic [BITCNT_W-1:0] BIT_LAST     = BITCNT_W'(FRAME_BITS - 1);
    localparam logic [RETRY_W-1:0]  RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    tx_state_t             state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic                  timeout_q, timeout_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                  ack_s;
    logic                  load;
    logic                  serial_bit;
    logic                  frame_bit;
    logic                  timer_run;

    // Acknowledge comes from another clock domain: two-flop synchroniser
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], acknowledge};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    fpga_shift_register_param #(
        .DATA_WIDTH (DATA_WIDTH),
        .LSB_FIRST  (LSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .data_i   (data_in),
        .shift_i  (state_q == SHIFT),
        .serial_o (serial_bit)
    );

`ifdef FPGA_TX_PARITY_EN
    logic parity_q;

    // Even parity of the payload, fixed at load time
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^data_in;
        end
    end

    assign frame_bit = (bit_cnt_q == BITCNT_W'(DATA_WIDTH)) ? parity_q : serial_bit;
`else
    assign frame_bit = serial_bit;
`endif

    // Next-state logic; acknowledge is tested before the timer so it wins a tie
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        timeout_d = 1'b0;
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    retry_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_d = SHIFT;
                end else if (timer_q == TIMER_LAST) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 1'b1;
                        state_d = BACKOFF;
                    end else begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            BACKOFF: begin
                if (timer_q == BACKOFF_LAST) begin
                    state_d = REQ;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (!ack_s) begin
                    state_d = DONE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign timer_run = (state_q == REQ) || (state_q == BACKOFF) || (state_q == FINISH);

    // Counters restart on every state change and saturate instead of wrapping
    always_comb begin
        timer_d   = '0;
        bit_cnt_d = '0;
        if (state_d == state_q) begin
            if (timer_run) begin
                timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
            end
            if (state_q == SHIFT) begin
                bit_cnt_d = (bit_cnt_q == BIT_LAST) ? bit_cnt_q : bit_cnt_q + 1'b1;
            end
        end
    end

    // State, counters and the registered abort pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            retry_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            retry_q   <= retry_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs decode the registered state so reset clears them immediately
    assign busy          = (state_q != IDLE);
    assign send_to_other = (state_q == REQ) || (state_q == SHIFT);
    assign data_valid    = (state_q == SHIFT);
    assign data_out      = (state_q == SHIFT) ? frame_bit : 1'b0;
    assign finish        = (state_q == FINISH);
    assign finish_sent   = (state_q == DONE);
    assign timeout_err   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_fpga_transmitter_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpga_transmitter_param
//  Description : Self-checking bench; two transmitters (LSB-first and
//                MSB-first) share the stimulus, a queue scoreboard checks bits.
//  Revision    : 1.0
// ============================================================================
module tb_fpga_transmitter_param;

`ifdef FPGA_TX_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       acknowledge = 1'b0;

    logic l_busy, l_sto, l_dout, l_dv, l_fin, l_fs, l_te;
    logic m_busy, m_sto, m_dout, m_dv, m_fin, m_fs, m_te;

    int checks = 0;
    int errors = 0;
    int l_vcnt = 0;
    int m_vcnt = 0;
    int fs_cnt = 0;
    int te_cnt = 0;
    bit exp_l[$];
    bit exp_m[$];

    always #5 clk = ~clk;

    fpga_transmitter_param #(
        .DATA_WIDTH(8), .ACK_TIMEOUT(10), .MAX_RETRY(2), .LSB_FIRST(1)
    ) u_lsb (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .busy(l_busy),
        .acknowledge(acknowledge), .send_to_other(l_sto), .data_out(l_dout),
        .data_valid(l_dv), .finish(l_fin), .finish_sent(l_fs), .timeout_err(l_te)
    );

    fpga_transmitter_param #(
        .DATA_WIDTH(8), .ACK_TIMEOUT(10), .MAX_RETRY(2), .LSB_FIRST(0)
    ) u_msb (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .busy(m_busy),
        .acknowledge(acknowledge), .send_to_other(m_sto), .data_out(m_dout),
        .data_valid(m_dv), .finish(m_fin), .finish_sent(m_fs), .timeout_err(m_te)
    );

    // Scoreboard: every valid bit is popped and compared
    always @(negedge clk) begin
        bit e;
        if (reset) begin
            if (l_dv) begin
                l_vcnt++;
                checks++;
                if (exp_l.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_bit: unexpected data_valid, data_out=%b", l_dout);
                end else begin
                    e = exp_l.pop_front();
                    if (l_dout !== e) begin
                        errors++;
                        $display("FAIL lsb_bit %0d: got %b expected %b", l_vcnt, l_dout, e);
                    end
                end
            end
            if (m_dv) begin
                m_vcnt++;
                checks++;
                if (exp_m.size() == 0) begin
                    errors++;
                    $display("FAIL msb_bit: unexpected data_valid, data_out=%b", m_dout);
                end else begin
                    e = exp_m.pop_front();
                    if (m_dout !== e) begin
                        errors++;
                        $display("FAIL msb_bit %0d: got %b expected %b", m_vcnt, m_dout, e);
                    end
                end
            end
            if (l_fs) fs_cnt++;
            if (l_te) te_cnt++;
        end
    end

    function automatic void push_frame(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            exp_l.push_back(d[i]);
            exp_m.push_back(d[7-i]);
        end
`ifdef FPGA_TX_PARITY_EN
        exp_l.push_back(^d);
        exp_m.push_back(^d);
`endif
    endfunction

    task automatic clear_stats();
        l_vcnt = 0; m_vcnt = 0; fs_cnt = 0; te_cnt = 0;
    endtask

    // Returns on the negedge of the first REQ cycle
    task automatic start_frame(input logic [7:0] d, input bit push);
        @(negedge clk);
        data_in = d;
        start   = 1'b1;
        if (push) push_frame(d);
        @(negedge clk);
        start   = 1'b0;
        data_in = 8'h00;
    endtask

    // Remote receiver: ack after a delay, drop it on finish, wait for idle
    task automatic remote_handshake(input int delay);
        int n;
        n = 0;
        while (!l_sto && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!l_sto) begin errors++; $display("FAIL wait_request: send_to_other=%b required 1", l_sto); end
        repeat (delay) @(negedge clk);
        acknowledge = 1'b1;
        n = 0;
        while (!l_fin && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!l_fin) begin errors++; $display("FAIL wait_finish: finish=%b required 1", l_fin); end
        acknowledge = 1'b0;
        n = 0;
        while (l_busy && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (l_busy) begin errors++; $display("FAIL wait_idle: busy=%b required 0", l_busy); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({l_busy, l_sto, l_dout, l_dv, l_fin, l_fs, l_te} !== 7'b0) begin
            errors++;
            $display("FAIL reset_lsb: outputs=%b required 0000000",
                     {l_busy, l_sto, l_dout, l_dv, l_fin, l_fs, l_te});
        end
        checks++;
        if ({m_busy, m_sto, m_dout, m_dv, m_fin, m_fs, m_te} !== 7'b0) begin
            errors++;
            $display("FAIL reset_msb: outputs=%b required 0000000",
                     {m_busy, m_sto, m_dout, m_dv, m_fin, m_fs, m_te});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lsb_order(input logic [7:0] d);
        clear_stats();
        start_frame(d, 1'b1);
        checks++;
        if (l_busy !== 1'b1) begin errors++; $display("FAIL busy_rise: busy=%b required 1", l_busy); end
        remote_handshake(3);
        checks++;
        if (l_vcnt != FB) begin errors++; $display("FAIL lsb_valid_count: got %0d required %0d", l_vcnt, FB); end
        checks++;
        if (fs_cnt != 1) begin errors++; $display("FAIL finish_sent_cycles: got %0d required 1", fs_cnt); end
        checks++;
        if (te_cnt != 0) begin errors++; $display("FAIL lsb_timeout_err: got %0d required 0", te_cnt); end
        checks++;
        if (exp_l.size() != 0) begin errors++; $display("FAIL lsb_leftover: got %0d required 0", exp_l.size()); end
    endtask

    task automatic test_msb_order(input logic [7:0] d);
        clear_stats();
        start_frame(d, 1'b1);
        remote_handshake(3);
        checks++;
        if (m_vcnt != FB) begin errors++; $display("FAIL msb_valid_count: got %0d required %0d", m_vcnt, FB); end
        checks++;
        if (exp_m.size() != 0) begin errors++; $display("FAIL msb_leftover: got %0d required 0", exp_m.size()); end
        checks++;
        if (m_fs !== 1'b0 || m_busy !== 1'b0) begin
            errors++; $display("FAIL msb_idle: finish_sent=%b busy=%b required 0 0", m_fs, m_busy);
        end
    endtask

    // Ack never arrives: three 10-cycle windows, 2-cycle gaps, one abort pulse
    task automatic test_timeout();
        bit e_sto, e_te, e_busy;
        clear_stats();
        acknowledge = 1'b0;
        start_frame(8'h5A, 1'b0);
        for (int i = 0; i < 38; i++) begin
            e_sto  = (i < 10) || (i >= 12 && i < 22) || (i >= 24 && i < 34);
            e_te   = (i == 34);
            e_busy = (i < 34);
            checks++;
            if ({l_sto, l_te, l_busy} !== {e_sto, e_te, e_busy}) begin
                errors++;
                $display("FAIL timeout_cycle %0d: sto/te/busy=%b required %b",
                         i, {l_sto, l_te, l_busy}, {e_sto, e_te, e_busy});
            end
            @(negedge clk);
        end
        checks++;
        if (te_cnt != 1 || l_vcnt != 0) begin
            errors++; $display("FAIL timeout_summary: te=%0d valid=%0d required 1 0", te_cnt, l_vcnt);
        end
    endtask

    // Ack shows up in the second request window
    task automatic test_retry_success();
        int n;
        clear_stats();
        start_frame(8'hC3, 1'b1);
        for (int i = 0; i < 14; i++) begin
            if (i == 10) begin
                checks++;
                if (l_sto !== 1'b0) begin errors++; $display("FAIL backoff_gap: sto=%b required 0", l_sto); end
            end
            if (i == 12) begin
                checks++;
                if (l_sto !== 1'b1) begin errors++; $display("FAIL second_window: sto=%b required 1", l_sto); end
            end
            if (i < 13) @(negedge clk);
        end
        acknowledge = 1'b1;
        n = 0;
        while (!l_fin && n < 200) begin @(negedge clk); n++; end
        acknowledge = 1'b0;
        n = 0;
        while (l_busy && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++;
        if (fs_cnt != 1 || te_cnt != 0 || l_vcnt != FB) begin
            errors++;
            $display("FAIL retry_success: fs=%0d te=%0d valid=%0d required 1 0 %0d", fs_cnt, te_cnt, l_vcnt, FB);
        end
    endtask

    // Reset in the 4th shift cycle, then a clean frame
    task automatic test_reset_mid_shift();
        int n, k;
        clear_stats();
        acknowledge = 1'b1;
        repeat (3) @(negedge clk);
        start_frame(8'h96, 1'b1);
        n = 0; k = 0;
        while (k < 4 && n < 100) begin
            if (l_dv) k++;
            if (k < 4) begin @(negedge clk); n++; end
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({l_busy, l_sto, l_dout, l_dv, l_fin, l_fs, l_te, m_busy, m_sto, m_dv} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid_shift: outputs=%b required 0",
                     {l_busy, l_sto, l_dout, l_dv, l_fin, l_fs, l_te, m_busy, m_sto, m_dv});
        end
        checks++;
        if (exp_l.size() != FB - 4) begin
            errors++; $display("FAIL bits_before_reset: remaining %0d required %0d", exp_l.size(), FB - 4);
        end
        exp_l.delete();
        exp_m.delete();
        acknowledge = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (fs_cnt != 0 || te_cnt != 0) begin
            errors++; $display("FAIL reset_no_pulse: fs=%0d te=%0d required 0 0", fs_cnt, te_cnt);
        end
        clear_stats();
        start_frame(8'h3C, 1'b1);
        remote_handshake(3);
        checks++;
        if (l_vcnt != FB || fs_cnt != 1 || exp_l.size() != 0) begin
            errors++;
            $display("FAIL after_reset_frame: valid=%0d fs=%0d left=%0d required %0d 1 0",
                     l_vcnt, fs_cnt, exp_l.size(), FB);
        end
    endtask

    // Start while busy must not disturb the frame in flight
    task automatic test_back_to_back();
        clear_stats();
        start_frame(8'h07, 1'b1);
        @(negedge clk);
        data_in = 8'hFF;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        data_in = 8'h00;
        remote_handshake(3);
        checks++;
        if (l_vcnt != FB || m_vcnt != FB) begin
            errors++; $display("FAIL busy_ignore_count: lsb=%0d msb=%0d required %0d", l_vcnt, m_vcnt, FB);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (l_busy !== 1'b0 || fs_cnt != 1) begin
            errors++; $display("FAIL busy_ignore_idle: busy=%b fs=%0d required 0 1", l_busy, fs_cnt);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lsb_order(8'hA5);
        test_msb_order(8'hA5);
        test_msb_order(8'h81);
        test_timeout();
        test_retry_success();
        test_reset_mid_shift();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpga_transmitter_param.md
Name: fpga_transmitter_param

Overview:
- Parametrised successor of the FPGA-to-FPGA serial transmitter.
- Latches a DATA_WIDTH word from the local host, then requests the link from the remote receiver and waits for its acknowledge.
- Shifts the word out one bit per clock, then runs a finish handshake.
- Adds an acknowledge timeout with bounded retry, selectable bit order and an optional parity bit.
- Sits between the host-side logic and the inter-FPGA pins, paired with the matching receiver.

Parameters:
- DATA_WIDTH, 8: payload bits per frame (>=2).
- ACK_TIMEOUT, 255: clocks to wait for an acknowledge edge before the attempt counts as failed (>=4).
- MAX_RETRY, 3: re-requests after the first failed attempt before aborting (0..15).
- LSB_FIRST, 1: 1 = bit 0 is sent first; 0 = MSB is sent first.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  host request; sampled only when busy=0.
- data_in  input  DATA_WIDTH  payload; captured on the cycle start is accepted.
- busy  output  1  high from the cycle after acceptance until the return to IDLE.
- acknowledge  input  1  remote acknowledge; asynchronous to clk.
- send_to_other  output  1  link request to the remote FPGA.
- data_out  output  1  serial data.
- data_valid  output  1  high while data_out carries a frame bit.
- finish  output  1  end-of-frame indication to the remote FPGA.
- finish_sent  output  1  one-cycle pulse to the host: frame completed successfully.
- timeout_err  output  1  one-cycle pulse to the host: frame aborted.

Behaviour:
- Reset (async assert, sync release): state=IDLE; every output 0; shift register, bit counter, timer and retry counter cleared. Reset mid-frame aborts immediately and produces no pulse.
- acknowledge passes through an internal 2-flop synchroniser. All references below mean ack_s, which lags the pin by 2 cycles.
- IDLE:
  - start=1 -> load data_in into the shift register, clear retry, next state REQ.
  - busy rises on the following cycle.
- REQ:
  - send_to_other=1; timer increments each cycle.
  - ack_s=1 -> clear timer, next state SHIFT.
  - Timer reaches ACK_TIMEOUT with retry<MAX_RETRY -> retry++, next state BACKOFF.
  - Timer reaches ACK_TIMEOUT with retry==MAX_RETRY -> pulse timeout_err, next state IDLE.
- BACKOFF:
  - send_to_other=0 for exactly 2 cycles, timer cleared, then back to REQ.
- SHIFT:
  - data_valid=1; data_out = current bit, in the order set by LSB_FIRST.
  - Lasts exactly DATA_WIDTH cycles (DATA_WIDTH+1 with parity); then next state FINISH.
  - send_to_other stays 1 throughout. ack_s is ignored in this state.
- FINISH:
  - send_to_other=0, finish=1; timer runs.
  - ack_s=0 -> next state DONE.
  - Timeout -> pulse timeout_err, next state IDLE. No retry in this state.
- DONE:
  - finish=0; finish_sent=1 for one cycle; next state IDLE. busy falls on the next cycle.
- Simultaneous events:
  - start while busy=1 is ignored and data_in is not captured.
  - If ack_s rises on the same cycle the timer expires, the acknowledge wins.
- Counter widths: timer is $clog2(ACK_TIMEOUT+1) bits; bit counter is $clog2(DATA_WIDTH+1) bits. Neither counter wraps; both are cleared on every state entry.
- Minimum frame length (ack already high): 1 + 2 (sync) + DATA_WIDTH + finish handshake cycles.

Optional Feature:
- FPGA_TX_PARITY_EN defined: one extra bit follows the payload in SHIFT. It is the even parity (XOR of all payload bits), computed at load time, with data_valid=1 for that cycle.
- FPGA_TX_PARITY_EN undefined: no parity bit and no parity logic; SHIFT is exactly DATA_WIDTH cycles.

Decomposition:
- Package fpga_comm_pkg:
  - tx_state_t enum (IDLE, REQ, BACKOFF, SHIFT, FINISH, DONE).
  - BACKOFF_CYCLES=2.
  - SYNC_STAGES=2.
- Sub-module fpga_shift_register_param (DATA_WIDTH, LSB_FIRST):
  - Parallel load, shift enable, serial out.
  - Replaces the fixed 8-bit shift register.
- The FSM, timer and counters stay in the top module.

Test Plan:
- DATA_WIDTH=8, LSB_FIRST=1, data_in=8'hA5, ack raised 3 cycles after send_to_other -> data_out sequence 1,0,1,0,0,1,0,1 with data_valid high 8 cycles; then finish until ack drops; finish_sent pulse 1 cycle; timeout_err never.
- LSB_FIRST=0, data_in=8'hA5 -> 1,0,1,0,0,1,0,1 MSB-first. Repeat with 8'h81 -> 1,0,0,0,0,0,0,1.
- ACK_TIMEOUT=10, MAX_RETRY=2, ack held low -> 3 REQ windows of 10 cycles separated by 2-cycle send_to_other=0 gaps; then a single timeout_err pulse; busy=0; no data_valid.
- Ack first arrives during the 2nd REQ window -> frame completes normally; finish_sent=1, timeout_err=0.
- Reset asserted in the 4th SHIFT cycle -> all outputs 0 in the same cycle. After release, a new start with data_in=8'h3C transmits correctly.
- FPGA_TX_PARITY_EN defined, data_in=8'h07 -> 9 valid bits, 9th bit=1. With start pulsed while busy and data_in=8'hFF -> ignored, original frame unchanged.
